// File: rtl/tdm_multiplexer_if.sv
// Signal bundle for the 8-channel TDM serializer: frame request and channel data in,
// serialized slot bit, slot index and frame status out.
interface tdm_multiplexer_if;
    logic start;
    logic d0, d1, d2, d3, d4, d5, d6, d7;
    logic out;
    logic s0, s1, s2;
    logic valid;
    logic busy;
    logic done;
    logic par_slot;

    modport master (
        output start, d0, d1, d2, d3, d4, d5, d6, d7,
        input  out, s0, s1, s2, valid, busy, done, par_slot
    );

    modport slave (
        input  start, d0, d1, d2, d3, d4, d5, d6, d7,
        output out, s0, s1, s2, valid, busy, done, par_slot
    );
endinterface

// File: rtl/tdm_multiplexer.sv
// 8-channel TDM serializer: latches d7..d0 on start, emits one bit per slot held HOLD_CYCLES clocks.
// Optional trailing parity slot compiled in with macro TDM_PARITY_EN.
module tdm_multiplexer #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    tdm_multiplexer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SEND, PAR, DONE} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t     state, state_n;
    logic [7:0] frame, frame_n;
    logic [2:0] slot, slot_n;
    logic [3:0] hold, hold_n;
    logic [7:0] d_in;
    logic       hold_end;

    logic       out_q, valid_q, busy_q, done_q;
    logic [2:0] s_q;
    logic       out_n, valid_n, busy_n, done_n;
    logic [2:0] s_n;

    assign d_in     = {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0};
    assign hold_end = (hold == HOLD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            frame <= '0;
            slot  <= '0;
            hold  <= '0;
        end else begin
            state <= state_n;
            frame <= frame_n;
            slot  <= slot_n;
            hold  <= hold_n;
        end
    end

    always_comb begin
        state_n = state;
        frame_n = frame;
        slot_n  = slot;
        hold_n  = hold;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    frame_n = d_in;
                    slot_n  = '0;
                    hold_n  = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (hold_end) begin
                    hold_n = '0;
                    slot_n = slot + 3'd1;   // wraps to 0 after slot 7
                    if (slot == 3'd7) begin
`ifdef TDM_PARITY_EN
                        state_n = PAR;
`else
                        state_n = DONE;
`endif
                    end
                end else begin
                    hold_n = hold + 4'd1;
                end
            end
`ifdef TDM_PARITY_EN
            PAR: begin
                if (hold_end) begin
                    hold_n  = '0;
                    state_n = DONE;
                end else begin
                    hold_n = hold + 4'd1;
                end
            end
`endif
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change on the same
    // edge as the state and no input reaches an output combinationally.
    always_comb begin
        out_n   = 1'b0;
        s_n     = 3'b000;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        case (state_n)
            SEND: begin
                out_n   = frame_n[slot_n];
                s_n     = slot_n;
                valid_n = 1'b1;
                busy_n  = 1'b1;
            end
`ifdef TDM_PARITY_EN
            PAR: begin
                out_n  = ^frame_n;
                busy_n = 1'b1;
            end
`endif
            DONE: begin
                done_n = 1'b1;
                busy_n = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= 1'b0;
            s_q     <= 3'b000;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            out_q   <= out_n;
            s_q     <= s_n;
            valid_q <= valid_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

`ifdef TDM_PARITY_EN
    logic par_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) par_q <= 1'b0;
        else       par_q <= (state_n == PAR);
    end
    assign bus.par_slot = par_q;
`else
    assign bus.par_slot = 1'b0;
`endif

    assign bus.out   = out_q;
    assign bus.s0    = s_q[0];
    assign bus.s1    = s_q[1];
    assign bus.s2    = s_q[2];
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_tdm_multiplexer.sv
// Scoreboard bench for tdm_multiplexer: expected per-cycle output words are queued when a
// frame is requested and compared one per clock; HOLD_CYCLES=1 and 3 instances side by side.
module tb_tdm_multiplexer;
    logic clk;
    logic reset;
    int   passed;
    int   total;

    // Expected word layout: {out, s2, s1, s0, valid, busy, done, par_slot}
    logic [7:0] q[$];

    tdm_multiplexer_if i1 ();
    tdm_multiplexer_if i3 ();

    tdm_multiplexer #(.HOLD_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(i1.slave));
    tdm_multiplexer #(.HOLD_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .bus(i3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] obs1();
        return {i1.out, i1.s2, i1.s1, i1.s0, i1.valid, i1.busy, i1.done, i1.par_slot};
    endfunction

    function automatic logic [7:0] obs3();
        return {i3.out, i3.s2, i3.s1, i3.s0, i3.valid, i3.busy, i3.done, i3.par_slot};
    endfunction

    task automatic set_d1(input logic [7:0] v);
        {i1.d7, i1.d6, i1.d5, i1.d4, i1.d3, i1.d2, i1.d1, i1.d0} = v;
    endtask

    task automatic set_d3(input logic [7:0] v);
        {i3.d7, i3.d6, i3.d5, i3.d4, i3.d3, i3.d2, i3.d1, i3.d0} = v;
    endtask

    // Expected output words for one frame, plus the idle cycle that follows DONE.
    task automatic push_frame(input logic [7:0] d, input int h);
        logic [2:0] sl;
        for (int s = 0; s < 8; s++) begin
            sl = 3'(s);
            for (int c = 0; c < h; c++) q.push_back({d[s], sl, 4'b1100});
        end
`ifdef TDM_PARITY_EN
        for (int c = 0; c < h; c++) q.push_back({^d, 3'b000, 4'b0101});
`endif
        q.push_back(8'b0000_0110);
        q.push_back(8'h00);
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        #1;
        total++;
        if (obs1() !== 8'h00) $display("FAIL reset_h1: got %b want %b", obs1(), 8'h00);
        else passed++;
        total++;
        if (obs3() !== 8'h00) $display("FAIL reset_h3: got %b want %b", obs3(), 8'h00);
        else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        total++;
        if (obs1() !== 8'h00) $display("FAIL idle_after_reset: got %b want %b", obs1(), 8'h00);
        else passed++;
    endtask

    task automatic test_h1;
        logic [7:0] e;
        q.delete();
        @(negedge clk);
        set_d1(8'h04);
        i1.start = 1'b1;
        push_frame(8'h04, 1);
        while (q.size() > 0) begin
            @(negedge clk);
            i1.start = 1'b0;
            e = q.pop_front();
            total++;
            if (obs1() !== e) $display("FAIL h1_frame04: got %b want %b", obs1(), e);
            else passed++;
        end
    endtask

    // Random start pulses while busy must not spawn a second frame.
    task automatic test_h3;
        logic [7:0] e;
        q.delete();
        @(negedge clk);
        set_d3(8'hA5);
        i3.start = 1'b1;
        push_frame(8'hA5, 3);
        while (q.size() > 0) begin
            @(negedge clk);
            e = q.pop_front();
            total++;
            if (obs3() !== e) $display("FAIL h3_frameA5: got %b want %b", obs3(), e);
            else passed++;
            i3.start = (q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            set_d3(8'($urandom));
        end
    endtask

    task automatic test_data_change;
        logic [7:0] e;
        int n;
        q.delete();
        n = 0;
        @(negedge clk);
        set_d1(8'hFF);
        i1.start = 1'b1;
        push_frame(8'hFF, 1);
        while (q.size() > 0) begin
            @(negedge clk);
            n++;
            i1.start = 1'b0;
            if (n == 2) set_d1(8'h00);
            e = q.pop_front();
            total++;
            if (obs1() !== e) $display("FAIL data_change: got %b want %b", obs1(), e);
            else passed++;
        end
    endtask

    task automatic test_async_reset;
        logic [7:0] e;
        q.delete();
        @(negedge clk);
        set_d1(8'hFF);
        i1.start = 1'b1;
        push_frame(8'hFF, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            i1.start = 1'b0;
            e = q.pop_front();
            total++;
            if (obs1() !== e) $display("FAIL pre_abort: got %b want %b", obs1(), e);
            else passed++;
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (obs1() !== 8'h00) $display("FAIL async_clear: got %b want %b", obs1(), 8'h00);
        else passed++;
        q.delete();
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (obs1() !== 8'h00) $display("FAIL no_done_after_abort: got %b want %b", obs1(), 8'h00);
            else passed++;
        end
        set_d1(8'h3C);
        i1.start = 1'b1;
        push_frame(8'h3C, 1);
        while (q.size() > 0) begin
            @(negedge clk);
            i1.start = 1'b0;
            e = q.pop_front();
            total++;
            if (obs1() !== e) $display("FAIL post_reset_frame: got %b want %b", obs1(), e);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] e;
        logic [7:0] v;
        int n;
        int fr;
        q.delete();
        n  = 0;
        fr = 0;
        @(negedge clk);
        v = 8'h5A;
        set_d1(v);
        i1.start = 1'b1;
        push_frame(v, 1);
        while (q.size() > 0) begin
            @(negedge clk);
            n++;
            e = q.pop_front();
            total++;
            if (obs1() !== e) $display("FAIL back_to_back: got %b want %b", obs1(), e);
            else passed++;
            set_d1(8'($urandom));
            if (q.size() == 0) begin
                if (n < 30) begin
                    fr++;
                    v = 8'(32'h5A + fr * 37);
                    set_d1(v);
                    push_frame(v, 1);
                end else begin
                    i1.start = 1'b0;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (obs1() !== 8'h00) $display("FAIL b2b_stop: got %b want %b", obs1(), 8'h00);
            else passed++;
        end
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        reset    = 1'b0;
        i1.start = 1'b0;
        i3.start = 1'b0;
        set_d1(8'h00);
        set_d3(8'h00);
        test_reset;
        test_h1;
        test_h3;
        test_data_change;
        test_async_reset;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/tdm_multiplexer.md
TDM_MULTIPLEXER -- requirements
Module: tdm_multiplexer

Interface
REQ-001 Parameter: HOLD_CYCLES, default 1, number of clocks each slot is held on the line; legal range 1..16.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  frame request; sampled on clk rising edge in IDLE only.
REQ-006 d0..d7  input  1 each  channel data; d0 is channel 0.
REQ-007 out  output  1  serialized channel bit for the current slot.
REQ-008 s0,s1,s2  output  1 each  channel index of the current slot; s2 is the MSB; drives a downstream 1-to-8 demultiplexer directly.
REQ-009 valid  output  1  high while out/s0..s2 carry a data slot.
REQ-010 busy  output  1  high from the cycle after start is accepted until done deasserts.
REQ-011 done  output  1  single-cycle pulse at end of frame.
REQ-012 par_slot  output  1  high during the parity slot (see Configuration).

Function
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-014 States: IDLE, SEND, PAR, DONE.
REQ-015 IDLE: out=0, s=000, valid=0, busy=0, done=0, par_slot=0.
REQ-016 IDLE with start=1 at edge k SHALL latch d7..d0 into an 8-bit frame register, set slot=0 and hold counter=0, and enter SEND; valid=1, busy=1 appear after edge k.
REQ-017 SEND: s2..s0 = slot, out = frame[slot], valid=1, busy=1.
REQ-018 Hold counter SHALL count 0..HOLD_CYCLES-1; at its terminal value, slot increments and the counter clears.
REQ-019 After the last hold cycle of slot 7: enter PAR if TDM_PARITY_EN is defined, else DONE; slot wraps to 0.
REQ-020 SEND occupies exactly 8*HOLD_CYCLES cycles.
REQ-021 DONE lasts one cycle: done=1, busy=1, valid=0, out=0, s=000; next state IDLE unconditionally.
REQ-022 start SHALL be ignored in SEND, PAR and DONE; a new frame can begin no earlier than the first IDLE cycle after DONE.
REQ-023 Changes on d0..d7 after the accepting edge SHALL NOT affect the frame in flight.
REQ-024 start held high continuously SHALL yield back-to-back frames separated by exactly one IDLE cycle.

Reset
REQ-025 reset=1 SHALL immediately, without waiting for clk, force state IDLE, frame=0, slot=0, hold counter=0 and all outputs to the REQ-015 values.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no done pulse; the first frame after release starts only on a new start sampled in IDLE.

Configuration
REQ-027 Macro TDM_PARITY_EN: when defined, PAR state is compiled in and lasts HOLD_CYCLES cycles with out = XOR of frame[7:0], s=000, valid=0, par_slot=1, busy=1, then DONE.
REQ-028 Without TDM_PARITY_EN: no PAR state logic; par_slot SHALL be constant 0; SEND proceeds directly to DONE.

Verification
REQ-029 HOLD_CYCLES=1, d=8'b0000_0100, start pulse at edge 0 -> edges 1..8 show s=000..111; out=1 only when s=010; done=1 at cycle 9 (cycle 10 with parity, par_slot=1 and out=1 at cycle 9).
REQ-030 HOLD_CYCLES=3, d=8'hA5 -> each s value held 3 cycles; out sequence 1,0,1,0,0,1,0,1; done after 24 SEND cycles (+3 PAR cycles with parity, out=0).
REQ-031 d=8'hFF latched, then d forced to 8'h00 at edge 2 -> out stays 1 for all 8 slots.
REQ-032 Reset asserted asynchronously between edges during slot 4 -> all outputs 0 before the next edge; no done pulse; start afterwards -> clean frame from slot 0.
REQ-033 start held high for 30 cycles, HOLD_CYCLES=1, no parity -> frames of 8 valid cycles, done, one IDLE cycle, repeat; start pulses during SEND produce no extra frame.
